// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: owns L/R, C/D and the round counter and steps one
// external f-datapath through 16 rounds, one round per clock.
module des_round_sequencer #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [63:0] in_data,
    input  logic [55:0] in_cd,
    output logic [31:0] round_right,
    output logic [55:0] round_cd,
    input  logic [31:0] f_in,
    output logic        round_active,
    output logic [4:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam logic [4:0] LastRound = 5'(ROUNDS);

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [55:0] cd_q, cd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [63:0] out_q, out_d;

    logic [4:0]  next_round;
    logic        shift_one;

    // Rotate a 28-bit key half by one or two places; decrypt walks the schedule backwards.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic dec,
                                          input logic two);
        if (!dec) begin
            return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        end
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign next_round = cnt_q + 5'd1;
    assign shift_one  = (next_round == 5'd2) || (next_round == 5'd9) || (next_round == 5'd16);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    l_d    = in_data[63:32];
                    r_d    = in_data[31:0];
                    mode_d = in_mode;
                    cnt_d  = 5'd1;
                    // C16D16 equals C0D0, so decrypt starts from the unshifted key.
                    cd_d   = in_mode ? in_cd
                                     : {rot28(in_cd[55:28], 1'b0, 1'b0),
                                        rot28(in_cd[27:0], 1'b0, 1'b0)};
                    state_d = StRound;
                end
            end
            StRound: begin
                l_d   = r_q;
                r_d   = l_q ^ f_in;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LastRound) begin
                    out_d   = {l_q ^ f_in, r_q};
                    state_d = StDone;
                end else begin
                    cd_d = {rot28(cd_q[55:28], mode_q, !shift_one),
                            rot28(cd_q[27:0], mode_q, !shift_one)};
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        in_ready     = (state_q == StIdle);
        round_active = (state_q == StRound);
        out_valid    = (state_q == StDone);
        round_idx    = round_active ? cnt_q : 5'd0;
        round_right  = r_q;
        round_cd     = cd_q;
        out_data     = out_q;
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: wraps the sequencer with a DES f-function model and checks it
// every cycle against a block-level DES model, plus directed known-answer vectors.
module tb_des_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mode;
    logic [63:0] in_data;
    logic [55:0] in_cd;
    logic [31:0] round_right;
    logic [55:0] round_cd;
    logic [31:0] f_in;
    logic        round_active;
    logic [4:0]  round_idx;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic        f_zero;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    des_round_sequencer #(.ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .in_cd(in_cd), .round_right(round_right),
        .round_cd(round_cd), .f_in(f_in), .round_active(round_active),
        .round_idx(round_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int e_t [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
                       46,42,50,36,29,32};
    int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sbox [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] do_ip(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-ip_t[i]];
        return r;
    endfunction

    function automatic logic [63:0] do_fp(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-fp_t[i]];
        return r;
    endfunction

    function automatic logic [55:0] do_pc1(input logic [63:0] x);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = x[64-pc1_t[i]];
        return r;
    endfunction

    function automatic logic [47:0] do_pc2(input logic [55:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[56-pc2_t[i]];
        return r;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [55:0] cd);
        logic [47:0] x, ex;
        logic [31:0] s, p;
        logic [5:0]  six;
        int row, col, v;
        for (int i = 0; i < 48; i++) ex[47-i] = r[32-e_t[i]];
        x = ex ^ do_pc2(cd);
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = {30'd0, six[5], six[0]};
            col = {28'd0, six[4:1]};
            v = sbox[b*64 + row*16 + col];
            s[31-4*b -: 4] = 4'(v);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-p_t[i]];
        return p;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input int s);
        if (s % 28 == 0) return x;
        return (x << (s % 28)) | (x >> (28 - (s % 28)));
    endfunction

    // Key state used by encryption round k: both halves rotated by the cumulative shift count.
    function automatic logic [55:0] sched(input logic [55:0] cd0, input int k);
        int s = 0;
        for (int j = 0; j < k; j++) s += sh_t[j];
        return {rol28(cd0[55:28], s), rol28(cd0[27:0], s)};
    endfunction

    always_comb f_in = f_zero ? 32'h0 : des_f(round_right, round_cd);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: phase 0 idle, 1..16 round number, 17 result held.
    int          m_phase;
    logic [31:0] m_r [1:16];
    logic [55:0] m_cd [1:16];
    logic [63:0] m_exp, m_out;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] ml, mr, fv;
        logic [55:0] cdv;
        int k;
        if (!rst_n) begin
            m_phase <= 0;
            m_out   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    ml = in_data[63:32];
                    mr = in_data[31:0];
                    for (int i = 1; i <= 16; i++) begin
                        k = in_mode ? 17 - i : i;
                        cdv = sched(in_cd, k);
                        m_r[i]  <= mr;
                        m_cd[i] <= cdv;
                        fv = f_zero ? 32'h0 : des_f(mr, cdv);
                        {ml, mr} = {mr, ml ^ fv};
                    end
                    m_exp   <= {mr, ml};
                    m_phase <= 1;
                end
                16: begin
                    m_out   <= m_exp;
                    m_phase <= 17;
                end
                17: if (out_ready) m_phase <= 0;
                default: m_phase <= m_phase + 1;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic act;
        act = (m_phase >= 1) && (m_phase <= 16);
        check("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 0});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 17});
        check("round_active", {63'd0, round_active}, {63'd0, act});
        check("round_idx", {59'd0, round_idx}, act ? 64'(m_phase) : 64'd0);
        check("out_data", out_data, m_out);
        if (act) begin
            check("round_right", {32'd0, round_right}, {32'd0, m_r[m_phase]});
            check("round_cd", {8'd0, round_cd}, {8'd0, m_cd[m_phase]});
        end
        if (!rst_n) begin
            check("rst_right", {32'd0, round_right}, 64'd0);
            check("rst_cd", {8'd0, round_cd}, 64'd0);
        end
    end

    logic [55:0] cap_cd [1:16];
    logic [4:0]  cap_idx [1:16];

    task automatic run_block(input logic mode, input logic [63:0] data, input logic [55:0] cd,
                             output logic [63:0] res);
        int lat;
        @(negedge clk);
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_cd    = cd;
        @(posedge clk);
        #1;
        // Inputs scrambled after accept must not disturb the block in flight.
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_data  = ~data;
        in_cd    = ~cd;
        cap_idx[1] = round_idx;
        cap_cd[1]  = round_cd;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat <= 15) begin
                cap_idx[lat+1] = round_idx;
                cap_cd[lat+1]  = round_cd;
            end
        end
        check("latency", 64'(lat), 64'd16);
        res = out_data;
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("done_one_cycle", {63'd0, out_valid}, 64'd0);
            check("ready_after_done", {63'd0, in_ready}, 64'd1);
        end
    endtask

    localparam logic [63:0] Key = 64'h133457799BBCDFF1;
    localparam logic [63:0] Pt  = 64'h0123456789ABCDEF;
    localparam logic [63:0] Ct  = 64'h85E813540F0AB405;

    initial begin
        logic [63:0] res, hold;
        logic [55:0] kcd;
        int n, seen;
        rst_n = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_cd = '0;
        out_ready = 1'b1; f_zero = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_idx", {59'd0, round_idx}, 64'd0);
        check("reset_out_data", out_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        kcd = do_pc1(Key);
        check("model_pc1", {8'd0, kcd}, 64'h00F0CCAAF556678F);
        check("model_ip", do_ip(Pt), 64'hCC00CCFFF0AAF0AA);
        check("model_fp_ip", do_fp(do_ip(Pt)), Pt);

        f_zero = 1'b1;
        run_block(1'b0, Pt, kcd, res);
        check("fzero_out", res, 64'h89ABCDEF01234567);
        f_zero = 1'b0;

        run_block(1'b0, do_ip(Pt), kcd, res);
        check("encrypt_ct", do_fp(res), Ct);
        check("encrypt_cd16", {8'd0, cap_cd[16]}, {8'd0, kcd});

        run_block(1'b1, do_ip(Ct), kcd, res);
        check("decrypt_pt", do_fp(res), Pt);
        check("decrypt_cd1", {8'd0, cap_cd[1]}, 64'h00F0CCAAF556678F);

        run_block(1'b0, 64'hA5A5F00F0FF05A5A, 56'h80000008000000, res);
        check("probe_cd1", {8'd0, cap_cd[1]}, 64'h0000000010000001);
        check("probe_cd16", {8'd0, cap_cd[16]}, 64'h0080000008000000);
        for (int i = 1; i <= 16; i++) check("probe_idx", {59'd0, cap_idx[i]}, 64'(i));

        out_ready = 1'b0;
        run_block(1'b0, do_ip(Pt), kcd, res);
        hold = res;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_mode  = 1'b1;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", out_data, hold);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("bp_released", {63'd0, out_valid}, 64'd0);
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        check("bp_no_second", {63'd0, round_active}, 64'd0);
        check("bp_ct", do_fp(hold), Ct);

        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = do_ip(Pt); in_cd = kcd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 5'd7 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_round7", {59'd0, round_idx}, 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_idx", {59'd0, round_idx}, 64'd0);
        check("arst_active", {63'd0, round_active}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_right", {32'd0, round_right}, 64'd0);
        check("arst_cd", {8'd0, round_cd}, 64'd0);
        check("arst_out_data", out_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("arst_no_output", 64'(seen), 64'd0);
        run_block(1'b0, do_ip(Pt), kcd, res);
        check("after_rst_ct", do_fp(res), Ct);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Iterative DES round controller. Sequences one shared round datapath (expansion permutation, subkey XOR, S-boxes, P-permutation) through 16 rounds, one round per clock.
- Owns the L/R state registers, the C/D key-schedule registers and the round counter.
- Presents the current right half and C/D state to the external f-datapath and takes f(R,K) back combinationally.
- Sits between the IP/PC-1 front end and the FP back end in the UART cipher path.

Parameters:
- ROUNDS, 16, number of rounds; fixed at 16 for DES. Counter width is 5 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block and key valid
- in_ready  out  1  block can accept; high only in IDLE
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- in_data  in  64  post-IP block, {L0[63:32], R0[31:0]}
- in_cd  in  56  post-PC-1 key, {C0[55:28], D0[27:0]}
- round_right  out  32  current R register; feeds the expansion permutation
- round_cd  out  56  current C/D register; feeds external PC-2 to form the round subkey
- f_in  in  32  f(round_right, PC2(round_cd)) from the external datapath, combinational
- round_active  out  1  high during ROUND state; f_in is used only when this is high
- round_idx  out  5  current round, 1..16; 0 when not in ROUND
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  downstream accepts
- out_data  out  64  pre-FP output {R16, L16}

Behaviour:
- Reset:
  - state = IDLE; L, R, CD, counter and out_data cleared to 0.
  - in_ready = 1; out_valid = 0; round_active = 0; round_idx = 0.
  - Reset asserted mid-operation aborts the block with no output.
- States: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge E0:
    - L <= in_data[63:32]; R <= in_data[31:0]; latch mode; counter <= 1; go to ROUND.
    - Encrypt: CD <= {C0 rol 1, D0 rol 1}, i.e. the round-1 key state.
    - Decrypt: CD <= {C0, D0} unshifted, since C16D16 == C0D0.
- ROUND:
  - Each edge: L <= R; R <= L ^ f_in.
  - C/D advance for the next round. C and D rotate independently within 28 bits.
  - Encrypt next-round rotation: rotate left 1 when the next round is in {2, 9, 16}, otherwise rotate left 2.
  - Decrypt next-round rotation: rotate right 1 when the next round is in {2, 9, 16}, otherwise rotate right 2.
  - counter increments each edge.
  - At edge E16 (counter == 16):
    - out_data <= {L ^ f_in, R}, which is {R16, L16} with the final swap applied.
    - Go to DONE. CD need not advance on this edge.
- DONE:
  - out_valid = 1; out_data held stable.
  - On out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.
- Timing:
  - Latency from accept edge to out_valid high: 16 cycles (out_valid is high in the cycle after E16).
  - Minimum issue interval: 18 cycles.
- Conditions that must hold:
  - in_valid while not in IDLE is ignored; inputs are not sampled.
  - in_mode and in_cd changes after accept have no effect.
  - out_ready while not in DONE is ignored.
  - out_ready held high continuously: DONE lasts exactly 1 cycle.
  - Encrypt total rotation is 28 per half, so CD returns to {C0 rol 1, D0 rol 1} pattern consistency. A bench check: the round-16 CD equals C0D0.
  - round_cd and round_right are registered outputs; no combinational path from f_in to any output except the next-state registers.

Test Plan:
- f_in tied to 0, in_data = 0x0123456789ABCDEF -> out_valid exactly 16 cycles after accept, out_data = 0x89ABCDEF01234567.
- Encrypt through a bench wrapper (IP, PC-1, E, S-boxes, P, PC-2, FP models), key 0x133457799BBCDFF1, plaintext 0x0123456789ABCDEF -> ciphertext 0x85E813540F0AB405.
- Decrypt the same ciphertext with the same key -> plaintext 0x0123456789ABCDEF. round_cd in round 1 equals the PC-1 output.
- Key-schedule probe with encrypt, in_cd = 0x80000008000000:
  - round 1 round_cd = 0x00000010000001.
  - round 16 round_cd == in_cd.
  - round_idx steps 1..16.
- Backpressure: out_ready held low 5 cycles -> out_valid and out_data stable, in_ready stays 0, second in_valid ignored. Release -> one transfer, then in_ready = 1.
- rst_n pulsed low at round 7 -> all outputs return to reset values asynchronously. No out_valid afterwards. A new accept then completes normally.
